x_count_uart_tx: RTL and testbench
==================================

Name: x_count_uart_tx

Overview:
- Downstream consumer of the free-running 32-bit counter.
- On request, snapshots the 32-bit count and transmits it as four 8N1 UART bytes on a single serial line. Bytes go most-significant byte first; bits within each byte go LSB first.
- Lets the board report counter values to a host over one wire, replacing 32 parallel outputs.

Parameters:
- CLK_DIV, 16, clock cycles per UART bit period. Legal range 2..65535; divider width is $clog2(CLK_DIV).

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_count  input  32  counter value to be snapshotted; bit 31 is MSB
- i_send  input  1  transmit request, sampled on every rising edge
- o_tx  output  1  UART serial line; idle high
- o_busy  output  1  high while a frame is in progress
- o_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset is asynchronous, active-low, and takes effect immediately, including mid-frame. Reset values:
  - o_tx = 1, o_busy = 0, o_done = 0
  - state = IDLE; snapshot register, bit counter, byte counter and divider all = 0
- All outputs are registered; no combinational paths from inputs to outputs.
- States: IDLE, START, DATA, STOP.
  - IDLE: if i_send = 1 at edge t0, latch i_count into a 32-bit snapshot register and go to START. Otherwise stay in IDLE with o_tx = 1.
  - START: o_tx = 0 for CLK_DIV cycles, then go to DATA.
  - DATA: drive 8 bits of the current byte, LSB first, CLK_DIV cycles each, then go to STOP.
  - STOP: o_tx = 1 for CLK_DIV cycles. If byte index < 3, increment it and go to START; else go to IDLE.
- Byte order:
  - byte0 = snapshot[31:24]
  - byte1 = snapshot[23:16]
  - byte2 = snapshot[15:8]
  - byte3 = snapshot[7:0]
- Timing relative to capture edge t0:
  - o_tx goes low and o_busy goes high in cycle t0+1.
  - Line activity spans exactly 40*CLK_DIV cycles: t0+1 .. t0+40*CLK_DIV.
  - At edge t0+40*CLK_DIV the state returns to IDLE. o_busy = 0 and o_done = 1 for exactly one cycle after that edge.
- i_send while busy (any non-IDLE state) is ignored; there is no queue and no pending-request flag.
- Back-to-back frames: i_send held high restarts on the edge where o_done is high. Minimum gap is one idle-high cycle after the final stop bit.
- i_count may change at any time. Only the value present at the capture edge is transmitted.
- i_send asserted in the same cycle reset is released: ignored unless i_rst_n is high at that edge.
- Divider: counts 0..CLK_DIV-1 and advances the bit at terminal count. It is reset to 0 on every capture, so the first start bit is exactly CLK_DIV cycles long.
- Bit counter 0..7, byte counter 0..3. Neither wraps outside its state; both are cleared on capture.

Test Plan:
- Reset then idle, CLK_DIV=4 -> o_tx=1, o_busy=0, o_done=0 for 100 cycles with i_send=0.
- i_count=0x12345678, one-cycle i_send, CLK_DIV=4 -> line sampled mid-bit decodes bytes 0x12,0x34,0x56,0x78. Each frame is 0, 8 data bits LSB first, 1. o_busy high exactly 160 cycles; o_done single pulse on cycle 161.
- i_count=0xFFFFFFFF captured, then i_count changes to 0x00000000 at t0+1 -> transmitted bytes are 0xFF x4. Data bits all 1; only the start bits are low.
- Second i_send pulse at t0+50 while busy -> ignored. Exactly one frame sent; a single o_done pulse.
- i_rst_n driven low at t0+70 mid-DATA -> o_tx=1 and o_busy=0 asynchronously, before the next clock edge. A fresh i_send after release sends a complete new frame.
- i_send held high continuously, i_count=0xA5A5A5A5, CLK_DIV=2 -> consecutive frames with exactly one idle-high cycle between the last stop bit and the next start bit. o_done pulses every 81 cycles.

Source files
------------

// File: rtl/x_count_uart_tx.sv
// Snapshots a 32-bit count on request and sends it as four 8N1 UART bytes, MSB byte first, LSB bit first.
// Latency: line drops one cycle after the capture edge; frame occupies 40*CLK_DIV cycles, o_done one cycle after.
// Backpressure: none; i_send is ignored while busy (no queue), held i_send restarts on the o_done cycle.
module x_count_uart_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_count,
  input  logic        i_send,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_snap, w_snap_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [1:0]       r_byte, w_byte_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic             w_term;
  logic [2:0]       w_bit_inc;
  logic [7:0]       w_cur;

  assign w_term    = (r_div == DIV_LAST);
  assign w_bit_inc = r_bit + 3'd1;

  // Select the byte currently on the wire, most significant byte first
  always_comb begin
    w_cur = r_snap[31:24];
    unique case (r_byte)
      2'd0: w_cur = r_snap[31:24];
      2'd1: w_cur = r_snap[23:16];
      2'd2: w_cur = r_snap[15:8];
      2'd3: w_cur = r_snap[7:0];
      default: w_cur = r_snap[31:24];
    endcase
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered
  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_div_nxt   = w_term ? '0 : r_div + DIV_W'(1);
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_tx_nxt    = 1'b1;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        if (i_send) begin
          w_state_nxt = S_START;
          w_snap_nxt  = i_count;
          w_bit_nxt   = 3'd0;
          w_byte_nxt  = 2'd0;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_term) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = w_cur[0];
        end
      end
      S_DATA: begin
        w_tx_nxt = w_cur[r_bit];
        if (w_term) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt = w_bit_inc;
            w_tx_nxt  = w_cur[w_bit_inc];
          end
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_term) begin
          if (r_byte != 2'd3) begin
            w_state_nxt = S_START;
            w_byte_nxt  = r_byte + 2'd1;
            w_bit_nxt   = 3'd0;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State, datapath and registered outputs; reset forces an idle line immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_snap  <= w_snap_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_x_count_uart_tx.sv
// Bench for x_count_uart_tx: two instances (CLK_DIV=4 and CLK_DIV=2) against a frame-position model.
// The model tracks only "cycles since capture" and derives the line level from the 10-bit-per-byte frame layout.
// Directed scenarios pin the model with literal byte values, busy length, done position and frame spacing.
module tb_x_count_uart_tx;

  localparam int DA = 4;
  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        send [2];
  logic [31:0] cnt  [2];
  logic        tx   [2];
  logic        busy [2];
  logic        done [2];

  always #5 clk = ~clk;

  x_count_uart_tx #(.CLK_DIV(DA)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_count(cnt[0]), .i_send(send[0]),
    .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  x_count_uart_tx #(.CLK_DIV(DB)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_count(cnt[1]), .i_send(send[1]),
    .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dv(input int i);
    return (i == 0) ? DA : DB;
  endfunction

  // Line level n cycles into a frame (n = 1 is the first start-bit cycle)
  function automatic logic line_bit(input logic [31:0] snap, input int n, input int d);
    int b, pos, byte_i;
    logic [31:0] sh;
    logic [7:0] byt;
    b      = (n - 1) / d;
    pos    = b % 10;
    byte_i = b / 10;
    sh     = snap >> (8 * (3 - byte_i));
    byt    = sh[7:0];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return byt[pos - 1];
  endfunction

  // Reference model: a frame is active for 40*d cycles after the capture edge, then one done cycle
  bit          m_act  [2] = '{0, 0};
  int          m_n    [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  logic [31:0] m_snap [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i]  <= 1'b0;
        m_n[i]    <= 0;
        m_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (m_n[i] == 40 * dv(i)) begin
            m_act[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_n[i] <= m_n[i] + 1;
          end
        end else begin
          m_done[i] <= 1'b0;
          if (send[i]) begin
            m_act[i]  <= 1'b1;
            m_n[i]    <= 1;
            m_snap[i] <= cnt[i];
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model, away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic e_tx;
      e_tx = m_act[i] ? line_bit(m_snap[i], m_n[i], dv(i)) : 1'b1;
      check($sformatf("tx[%0d]", i),   32'(tx[i]),   32'(e_tx));
      check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_act[i]));
      check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i] & ~m_act[i]));
    end
  end

  logic rec_tx   [0:1023];
  logic rec_busy [0:1023];
  logic rec_done [0:1023];

  // Called at a negedge with the instance idle; records n cycles following the capture edge
  task automatic send_and_record(input int i, input logic [31:0] v, input logic [31:0] chg,
                                 input int extra_at, input int n);
    send[i] = 1'b1;
    cnt[i]  = v;
    @(negedge clk);
    send[i] = 1'b0;
    cnt[i]  = chg;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      if (c == extra_at) send[i] = 1'b1;
      if (c == extra_at + 1) send[i] = 1'b0;
      rec_tx[c]   = tx[i];
      rec_busy[c] = busy[i];
      rec_done[c] = done[i];
    end
    send[i] = 1'b0;
  endtask

  // Decodes the recorded line mid-bit and checks framing, bytes, busy length and done position
  task automatic check_frame(input string tag, input int d, input logic [31:0] v, input int n);
    int mid, nb, nd, first_d;
    logic [7:0] got;
    logic [31:0] sh;
    mid = d / 2 + 1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_start%0d", tag, k), 32'(rec_tx[10 * k * d + mid]), 32'd0);
      for (int j = 0; j < 8; j++) got[j] = rec_tx[(10 * k + 1 + j) * d + mid];
      sh = v >> (8 * (3 - k));
      check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(sh[7:0]));
      check($sformatf("%s_stop%0d", tag, k), 32'(rec_tx[(10 * k + 9) * d + mid]), 32'd1);
    end
    nb = 0; nd = 0; first_d = 0;
    for (int c = 1; c <= n; c++) begin
      if (rec_busy[c]) nb++;
      if (rec_done[c]) begin
        nd++;
        if (first_d == 0) first_d = c;
      end
    end
    check($sformatf("%s_busy_cycles", tag), 32'(nb), 32'(40 * d));
    check($sformatf("%s_done_count", tag), 32'(nd), 32'd1);
    check($sformatf("%s_done_pos", tag), 32'(first_d), 32'(40 * d + 1));
  endtask

  initial begin
    int last, np;
    logic [31:0] v;
    send[0] = 1'b0; send[1] = 1'b0;
    cnt[0]  = '0;   cnt[1]  = '0;
    #1 rst_n = 1'b0;
    #1 check("rst_tx", 32'(tx[0]), 32'd1);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle line for 100 cycles
    repeat (100) @(negedge clk);
    check("idle_tx", 32'(tx[0]), 32'd1);
    check("idle_busy", 32'(busy[0]), 32'd0);

    // Known pattern, count changes after capture
    send_and_record(0, 32'h12345678, $urandom, 0, 180);
    check_frame("f1234", DA, 32'h12345678, 180);

    // All ones captured, zeros presented afterwards, extra request mid-frame ignored
    send_and_record(0, 32'hFFFFFFFF, 32'h00000000, 50, 180);
    check_frame("fFF", DA, 32'hFFFFFFFF, 180);

    // Asynchronous reset in the middle of a data bit
    send[0] = 1'b1; cnt[0] = 32'hDEADBEEF;
    @(negedge clk);
    send[0] = 1'b0;
    repeat (69) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_tx", 32'(tx[0]), 32'd1);
    check("async_rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = $urandom;
    send_and_record(0, v, $urandom, 0, 180);
    check_frame("f_after_rst", DA, v, 180);

    // Held request: frames every 40*2+1 cycles with one idle-high cycle between
    send[1] = 1'b1; cnt[1] = 32'hA5A5A5A5;
    last = -1; np = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (done[1]) begin
        if (last < 0) check("b2b_first_done", 32'(c), 32'd81);
        else check("b2b_interval", 32'(c - last), 32'd81);
        check("b2b_gap_tx", 32'(tx[1]), 32'd1);
        last = c;
        np++;
      end
    end
    check("b2b_pulses", 32'(np), 32'd4);
    send[1] = 1'b0;

    // Random requests and counts on both instances
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        send[i] = ($urandom_range(0, 15) == 0);
        cnt[i]  = $urandom;
      end
    end
    send[0] = 1'b0; send[1] = 1'b0;
    repeat (200) @(negedge clk);
    check("end_busy_a", 32'(busy[0]), 32'd0);
    check("end_busy_b", 32'(busy[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
